matrix_out_streamer: RTL and testbench

//  Drain end of the matrix-multiply datapath. Captures one full N x N result

---
 rtl/matrix_out_streamer.sv | 106 ++++++++++
 tb/tb_matrix_out_streamer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/matrix_out_streamer.sv
// Captures an N x N matrix from a flat bus in one handshake and replays it as a
// tagged valid/ready element stream. Define MAT_STREAM_TRANSPOSE_EN for column-major order.
module matrix_out_streamer #(
    parameter int N = 2,
    parameter int W = 32,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*N*W-1:0]   in_mat,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_data,
    output logic [IW-1:0]      out_row,
    output logic [IW-1:0]      out_col,
    output logic               out_last,
    output logic               busy
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [IW-1:0] MAX_IDX = IW'(N - 1);

    state_t             state;
    logic [N*N*W-1:0]   mat_q;
    logic [IW-1:0]      row_nx;
    logic [IW-1:0]      col_nx;
    logic               last_nx;
    logic [W-1:0]       data_nx;

    // Next traversal position; only consumed when the current element is not the last.
    always_comb begin
        row_nx = out_row;
        col_nx = out_col;
`ifdef MAT_STREAM_TRANSPOSE_EN
        if (out_row == MAX_IDX) begin
            row_nx = '0;
            col_nx = out_col + 1'b1;
        end else begin
            row_nx = out_row + 1'b1;
        end
`else
        if (out_col == MAX_IDX) begin
            col_nx = '0;
            row_nx = out_row + 1'b1;
        end else begin
            col_nx = out_col + 1'b1;
        end
`endif
        last_nx = (row_nx == MAX_IDX) && (col_nx == MAX_IDX);
        data_nx = mat_q[(int'(row_nx) * N + int'(col_nx)) * W +: W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            mat_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mat_q     <= in_mat;
                        out_data  <= in_mat[W-1:0];
                        out_row   <= '0;
                        out_col   <= '0;
                        out_last  <= (N == 1);
                        out_valid <= 1'b1;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
                            out_row   <= '0;
                            out_col   <= '0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            out_data  <= data_nx;
                            out_row   <= row_nx;
                            out_col   <= col_nx;
                            out_last  <= last_nx;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_out_streamer.sv
// Directed bench for matrix_out_streamer: N=2, N=3 and N=1 instances on a shared clock/reset.
// Expected traversal follows MAT_STREAM_TRANSPOSE_EN when defined.
module tb_matrix_out_streamer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // N=2 instance
    logic         a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
    logic         a_out_last, a_busy;
    logic [127:0] a_in_mat = '0;
    logic [31:0]  a_out_data;
    logic [0:0]   a_out_row, a_out_col;

    matrix_out_streamer #(.N(2), .W(32)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_mat(a_in_mat), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_row(a_out_row), .out_col(a_out_col),
        .out_last(a_out_last), .busy(a_busy)
    );

    // N=3 instance
    logic         b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
    logic         b_out_last, b_busy;
    logic [287:0] b_in_mat = '0;
    logic [31:0]  b_out_data;
    logic [1:0]   b_out_row, b_out_col;

    matrix_out_streamer #(.N(3), .W(32)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_mat(b_in_mat), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_row(b_out_row), .out_col(b_out_col),
        .out_last(b_out_last), .busy(b_busy)
    );

    // N=1 instance
    logic         c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b1;
    logic         c_out_last, c_busy;
    logic [31:0]  c_in_mat = '0;
    logic [31:0]  c_out_data;
    logic [0:0]   c_out_row, c_out_col;

    matrix_out_streamer #(.N(1), .W(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_mat(c_in_mat), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .out_row(c_out_row), .out_col(c_out_col),
        .out_last(c_out_last), .busy(c_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Position of the k-th beat in traversal order for an n x n matrix.
    function automatic void pos(input int n, input int k, output int r, output int c);
`ifdef MAT_STREAM_TRANSPOSE_EN
        r = k % n;
        c = k / n;
`else
        r = k / n;
        c = k % n;
`endif
    endfunction

    task automatic cap2(input logic [127:0] m);
        a_in_valid = 1'b1;
        a_in_mat   = m;
        @(negedge clk);
        a_in_valid = 1'b0;
        chk("cap_valid", a_out_valid, 1'b1);
        chk("cap_busy", a_busy, 1'b1);
        chk("cap_in_ready", a_in_ready, 1'b0);
    endtask

    // Checks nbeats elements of a matrix holding base..base+3 row-major; ends at the
    // negedge after the final accepted beat. stall_k >= 0 holds out_ready low 3 cycles there.
    task automatic drain2(input int base, input int nbeats, input int stall_k);
        int r, c;
        for (int k = 0; k < nbeats; k++) begin
            pos(2, k, r, c);
            chk("d2_valid", a_out_valid, 1'b1);
            chk("d2_data", a_out_data, 64'(base + r * 2 + c));
            chk("d2_row", a_out_row, 64'(r));
            chk("d2_col", a_out_col, 64'(c));
            chk("d2_last", a_out_last, (k == 3) ? 1'b1 : 1'b0);
            if (k == stall_k) begin
                a_out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    chk("stall_valid", a_out_valid, 1'b1);
                    chk("stall_data", a_out_data, 64'(base + r * 2 + c));
                    chk("stall_row", a_out_row, 64'(r));
                    chk("stall_col", a_out_col, 64'(c));
                    chk("stall_last", a_out_last, 1'b0);
                end
                a_out_ready = 1'b1;
            end
            @(negedge clk);
        end
        if (nbeats == 4) begin
            chk("end_valid", a_out_valid, 1'b0);
            chk("end_in_ready", a_in_ready, 1'b1);
            chk("end_busy", a_busy, 1'b0);
        end
    endtask

    initial begin
        int r, c;
        // Reset state
        #12;
        chk("rst_in_ready", a_in_ready, 1'b1);
        chk("rst_valid", a_out_valid, 1'b0);
        chk("rst_data", a_out_data, 0);
        chk("rst_last", a_out_last, 1'b0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_row_col", {a_out_row, a_out_col}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic stream
        cap2({32'd4, 32'd3, 32'd2, 32'd1});
        drain2(1, 4, -1);

        // Stall at the second element
        cap2({32'd4, 32'd3, 32'd2, 32'd1});
        drain2(1, 4, 1);

        // in_valid held with a new matrix during STREAM is ignored, then captured
        cap2({32'd4, 32'd3, 32'd2, 32'd1});
        a_in_valid = 1'b1;
        a_in_mat   = {32'd8, 32'd7, 32'd6, 32'd5};
        drain2(1, 4, -1);
        @(negedge clk);
        a_in_valid = 1'b0;
        chk("recap_valid", a_out_valid, 1'b1);
        drain2(5, 4, -1);

        // Reset mid-stream
        cap2({32'd4, 32'd3, 32'd2, 32'd1});
        drain2(1, 2, -1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", a_out_valid, 1'b0);
        chk("mid_rst_in_ready", a_in_ready, 1'b1);
        chk("mid_rst_busy", a_busy, 1'b0);
        chk("mid_rst_data", a_out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cap2({32'd8, 32'd7, 32'd6, 32'd5});
        drain2(5, 4, -1);

        // N=3: elements 1..9
        for (int i = 0; i < 9; i++) b_in_mat[i*32 +: 32] = 32'(i + 1);
        b_in_valid = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            pos(3, k, r, c);
            chk("d3_valid", b_out_valid, 1'b1);
            chk("d3_data", b_out_data, 64'(r * 3 + c + 1));
            chk("d3_row", b_out_row, 64'(r));
            chk("d3_col", b_out_col, 64'(c));
            chk("d3_last", b_out_last, (k == 8) ? 1'b1 : 1'b0);
            @(negedge clk);
        end
        chk("d3_end_valid", b_out_valid, 1'b0);
        chk("d3_end_in_ready", b_in_ready, 1'b1);

        // N=1: single beat
        c_in_mat   = 32'hDEADBEEF;
        c_in_valid = 1'b1;
        @(negedge clk);
        c_in_valid = 1'b0;
        chk("d1_valid", c_out_valid, 1'b1);
        chk("d1_data", c_out_data, 64'hDEADBEEF);
        chk("d1_last", c_out_last, 1'b1);
        chk("d1_row_col", {c_out_row, c_out_col}, 0);
        @(negedge clk);
        chk("d1_end_valid", c_out_valid, 1'b0);
        chk("d1_end_in_ready", c_in_ready, 1'b1);
        chk("d1_end_busy", c_busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
